// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU result serializer: frame geometry,
// transmitter state encoding and the parity helper.
package alsu_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ERR   = 3'd3,
        ST_PAR   = 3'd4,
        ST_STOP  = 3'd5
    } tx_state_t;

    // Parity over {err, res}; odd=1 selects odd overall parity.
    function automatic logic parity_bit(input logic [DATA_BITS:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/alsu_result_fifo.sv
// Small synchronous FIFO for {err, res} words; pointers carry a wrap bit so
// full and empty are distinguished without an occupancy counter.
module alsu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // Head is read combinationally so the transmitter can load it on the pop edge.
    assign rdata = mem[rd_ptr_reg[AW-1:0]];
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/alsu_result_tx.sv
// Queues ALSU results and serializes each as a 10-bit UART-style frame
// (start, 6 data, err, parity, stop), sending frames back-to-back.
module alsu_result_tx
    import alsu_pkg::*;
#(
    parameter int    FIFO_DEPTH = 4,
    parameter int    BAUD_DIV   = 4,
    parameter string PARITY     = "EVEN"
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] res_in,
    input  logic       err_in,
    input  logic       res_valid,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic [7:0] frames_sent
);

    localparam logic            ODD_PARITY = (PARITY == "ODD");
    localparam int              BW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0]   BAUD_LAST  = BW'(BAUD_DIV - 1);
    localparam logic [2:0]      DATA_LAST  = 3'(DATA_BITS - 1);

    tx_state_t        state_reg, state_next;
    logic [BW-1:0]    baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [DATA_BITS:0] shift_reg, shift_next;
    logic             par_reg, par_next;
    logic             tx_reg, tx_next;
    logic             ovf_reg, ovf_next;
    logic [7:0]       frames_sent_reg, frames_sent_next;

    logic             fifo_full;
    logic             fifo_empty;
    logic [DATA_BITS:0] fifo_rdata;
    logic             fifo_push;
    logic             load;
    logic             bit_end;

    assign fifo_push = res_valid && !fifo_full;
    assign bit_end   = (baud_cnt_reg == BAUD_LAST);
    // A new frame starts from IDLE or directly at the end of STOP, so frames stay contiguous.
    assign load      = !fifo_empty &&
                       ((state_reg == ST_IDLE) || ((state_reg == ST_STOP) && bit_end));

    alsu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS + 1)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (load),
        .wdata ({err_in, res_in}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_next       = state_reg;
        baud_cnt_next    = baud_cnt_reg;
        bit_idx_next     = bit_idx_reg;
        shift_next       = shift_reg;
        par_next         = par_reg;
        tx_next          = tx_reg;
        frames_sent_next = frames_sent_reg;

        if (state_reg != ST_IDLE) begin
            baud_cnt_next = bit_end ? '0 : baud_cnt_reg + 1'b1;
        end

        case (state_reg)
            ST_IDLE: state_next = ST_IDLE;
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            ST_DATA: begin
                // Shifting right leaves err in bit 1 after the last data bit.
                if (bit_end) begin
                    shift_next = shift_reg >> 1;
                    tx_next    = shift_reg[1];
                    if (bit_idx_reg == DATA_LAST) begin
                        state_next = ST_ERR;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_ERR: begin
                if (bit_end) begin
                    state_next = ST_PAR;
                    tx_next    = par_reg;
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_next       = ST_IDLE;
                    tx_next          = 1'b1;
                    frames_sent_next = frames_sent_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        if (load) begin
            state_next    = ST_START;
            baud_cnt_next = '0;
            shift_next    = fifo_rdata;
            par_next      = parity_bit(fifo_rdata, ODD_PARITY);
            tx_next       = 1'b0;
        end
    end

    // Drop detection uses pre-edge fullness; a drop outranks a clear.
    always_comb begin
        ovf_next = ovf_reg;
        if (res_valid && fifo_full) begin
            ovf_next = 1'b1;
        end else if (clr_ovf) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            baud_cnt_reg    <= '0;
            bit_idx_reg     <= '0;
            shift_reg       <= '0;
            par_reg         <= 1'b0;
            tx_reg          <= 1'b1;
            ovf_reg         <= 1'b0;
            frames_sent_reg <= '0;
        end else begin
            state_reg       <= state_next;
            baud_cnt_reg    <= baud_cnt_next;
            bit_idx_reg     <= bit_idx_next;
            shift_reg       <= shift_next;
            par_reg         <= par_next;
            tx_reg          <= tx_next;
            ovf_reg         <= ovf_next;
            frames_sent_reg <= frames_sent_next;
        end
    end

    assign tx          = tx_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign full        = fifo_full;
    assign ovf         = ovf_reg;
    assign frames_sent = frames_sent_reg;

endmodule

// File: tb/tb_alsu_result_tx.sv
// Randomized scoreboard bench for alsu_result_tx: an EVEN and an ODD instance
// share stimulus; per-instance line monitors decode frames against a queue model.
module tb_alsu_result_tx;
    import alsu_pkg::*;

    localparam int DEPTH     = 4;
    localparam int B         = 4;
    localparam int FRAME_CYC = FRAME_BITS * B;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic [5:0] res_in    = '0;
    logic       err_in    = 1'b0;
    logic       res_valid = 1'b0;
    logic       clr_ovf   = 1'b0;

    logic       tx_w   [2];
    logic       busy_w [2];
    logic       full_w [2];
    logic       ovf_w  [2];
    logic [7:0] fs_w   [2];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alsu_result_tx #(
            .FIFO_DEPTH (DEPTH),
            .BAUD_DIV   (B),
            .PARITY     (gi == 0 ? "EVEN" : "ODD")
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .res_in      (res_in),
            .err_in      (err_in),
            .res_valid   (res_valid),
            .clr_ovf     (clr_ovf),
            .tx          (tx_w[gi]),
            .busy        (busy_w[gi]),
            .full        (full_w[gi]),
            .ovf         (ovf_w[gi]),
            .frames_sent (fs_w[gi])
        );
    end

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [6:0] words[$];          // every accepted {err,res}, in acceptance order
    int         mon_idx[2] = '{0, 0};

    // Abstract model: FIFO occupancy, cycles left in the current frame, counters.
    int   m_cnt    = 0;
    int   m_rem    = 0;
    int   m_frames = 0;
    logic m_ovf    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [6:0] w, input bit odd);
        logic par;
        par = (($countones(w) % 2) == 1) ^ odd;
        return {1'b1, par, w, 1'b0};
    endfunction

    task automatic cycle(input logic v, input logic [5:0] r, input logic e, input logic c);
        bit pre_full;
        res_valid = v;
        res_in    = r;
        err_in    = e;
        clr_ovf   = c;
        @(posedge clk);
        pre_full = (m_cnt == DEPTH);
        if (m_rem == 0) begin
            if (m_cnt > 0) begin
                m_cnt--;
                m_rem = FRAME_CYC;
            end
        end else if (m_rem == 1) begin
            m_frames = (m_frames + 1) % 256;
            if (m_cnt > 0) begin
                m_cnt--;
                m_rem = FRAME_CYC;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
        end
        if (v && pre_full) begin
            m_ovf = 1'b1;
        end else begin
            if (v) begin
                m_cnt++;
                words.push_back({e, r});
            end
            if (c) m_ovf = 1'b0;
        end
        @(negedge clk);
        res_valid = 1'b0;
        clr_ovf   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy[%0d]", i), busy_w[i], m_rem > 0);
            chk($sformatf("full[%0d]", i), full_w[i], m_cnt == DEPTH);
            chk($sformatf("ovf[%0d]", i), ovf_w[i], m_ovf);
            chk($sformatf("frames_sent[%0d]", i), fs_w[i], m_frames);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && (m_rem > 0 || m_cnt > 0); k++) begin
            cycle(1'b0, 6'd0, 1'b0, 1'b0);
        end
        idle(2);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        m_cnt    = 0;
        m_rem    = 0;
        m_frames = 0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_tx[%0d]", i), tx_w[i], 1);
            chk($sformatf("rst_busy[%0d]", i), busy_w[i], 0);
            chk($sformatf("rst_full[%0d]", i), full_w[i], 0);
            chk($sformatf("rst_ovf[%0d]", i), ovf_w[i], 0);
            chk($sformatf("rst_frames_sent[%0d]", i), fs_w[i], 0);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Line monitor: decodes each frame cycle by cycle against the next accepted word.
    task automatic monitor(input int gi);
        bit         in_frame = 1'b0;
        bit         bad      = 1'b0;
        int         pos      = 0;
        logic [9:0] exp_f    = '1;
        logic [9:0] got      = '1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame    = 1'b0;
                mon_idx[gi] = words.size();
            end else begin
                if (!in_frame && tx_w[gi] == 1'b0) begin
                    in_frame = 1'b1;
                    pos      = 0;
                    bad      = 1'b0;
                    got      = '1;
                    if (mon_idx[gi] < words.size()) begin
                        exp_f = frame_of(words[mon_idx[gi]], gi == 1);
                        mon_idx[gi]++;
                    end else begin
                        bad   = 1'b1;
                        exp_f = '1;
                    end
                end
                if (in_frame) begin
                    if (tx_w[gi] !== exp_f[pos / B]) bad = 1'b1;
                    if (pos % B == B / 2) got[pos / B] = tx_w[gi];
                    pos++;
                    if (pos == FRAME_CYC) begin
                        in_frame = 1'b0;
                        n_cmp++;
                        if (bad) begin
                            n_fail++;
                            $display("FAIL frame[%0d]: got %b required %b at %0t", gi, got, exp_f, $time);
                        end else begin
                            $display("frame[%0d] ok: %b at %0t", gi, got, $time);
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        logic [9:0] gold;
        int         pushed;
        logic       v;

        do_reset();
        idle(3);

        // Directed EVEN frame: 101101, err=0.
        cycle(1'b1, 6'b101101, 1'b0, 1'b0);
        gold = 10'b1001011010;
        for (int c = 0; c < FRAME_CYC; c++) begin
            cycle(1'b0, 6'd0, 1'b0, 1'b0);
            chk($sformatf("gold_even_c%0d", c), tx_w[0], gold[c / B]);
        end

        // Directed ODD frame: 000111, err=1.
        cycle(1'b1, 6'b000111, 1'b1, 1'b0);
        gold = 10'b1110001110;
        for (int c = 0; c < FRAME_CYC; c++) begin
            cycle(1'b0, 6'd0, 1'b0, 1'b0);
            chk($sformatf("gold_odd_c%0d", c), tx_w[1], gold[c / B]);
        end
        drain();

        // Four strobes on consecutive cycles.
        for (int k = 0; k < 4; k++) cycle(1'b1, 6'($urandom), 1'($urandom), 1'b0);
        drain();

        // Fill while transmitting, drop, clear, then clear coincident with a drop.
        for (int k = 0; k < 5; k++) cycle(1'b1, 6'($urandom), 1'($urandom), 1'b0);
        cycle(1'b1, 6'($urandom), 1'($urandom), 1'b0);
        cycle(1'b0, 6'd0, 1'b0, 1'b1);
        cycle(1'b1, 6'($urandom), 1'($urandom), 1'b1);
        idle(3);
        cycle(1'b0, 6'd0, 1'b0, 1'b1);
        drain();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 3) == 0, 6'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
        end
        drain();

        // Reset during the DATA bits, then a clean frame.
        cycle(1'b1, 6'($urandom), 1'($urandom), 1'b0);
        idle(1 + B + 2 * B);
        do_reset();
        cycle(1'b1, 6'($urandom), 1'($urandom), 1'b0);
        drain();

        // 256 frames from reset: counter wraps to 0.
        do_reset();
        pushed = 0;
        for (int k = 0; k < 20000 && pushed < 256; k++) begin
            v = (m_cnt < DEPTH) && (pushed < 256);
            cycle(v, 6'($urandom), 1'($urandom), 1'b0);
            if (v) pushed++;
        end
        drain();
        chk("wrap_even", fs_w[0], 0);
        chk("wrap_odd", fs_w[1], 0);

        idle(2);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("frames_delivered[%0d]", i), mon_idx[i], words.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
